hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter TAM_DIREC_REG, default 5, register address width.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1, range 1..7, bubble cycles inserted per load-use hazard.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_rs_if_id, i_rt_if_id  in  TAM_DIREC_REG  source registers of instruction in IF/ID.
REQ-006 i_uses_rt_if_id  in  1  IF/ID instruction reads rt.
REQ-007 i_rt_id_ex  in  TAM_DIREC_REG  destination of instruction in ID/EX.
REQ-008 i_mem_read_id_ex  in  1  ID/EX instruction is a load.
REQ-009 i_branch_taken, i_jump  in  1 each  control transfer resolved in ID this cycle.
REQ-010 i_halt  in  1  HALT instruction reached WB.
REQ-011 i_step_en, i_step_req  in  1 each  debug single-step mode; one-cycle advance request.
REQ-012 o_pipe_en  out  1  global pipeline-register enable.
REQ-013 o_pc_write, o_if_id_write  out  1 each  PC and IF/ID write enables.
REQ-014 o_id_ex_bubble  out  1  load NOP control into ID/EX.
REQ-015 o_if_id_flush  out  1  clear IF/ID.
REQ-016 o_halted  out  1  registered halt flag.
REQ-017 o_state  out  2  current FSM state.
REQ-018 o_stall_count  out  16  registered count of load-use bubble cycles.

Function
REQ-019 States SHALL be RUN=00, LOAD_STALL=01, HALTED=10; 11 SHALL return to RUN next edge with all enables deasserted that cycle.
REQ-020 hz SHALL = i_mem_read_id_ex & (i_rt_id_ex!=0) & ((i_rt_id_ex==i_rs_if_id) | (i_uses_rt_if_id & i_rt_id_ex==i_rt_if_id)).
REQ-021 adv SHALL = !i_step_en | i_step_req; o_pipe_en = adv & (state!=HALTED).
REQ-022 When adv=0 in RUN/LOAD_STALL: state, counter, o_stall_count SHALL hold; o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush SHALL be 0.
REQ-023 RUN, adv=1, hz=1: pc_write=0, if_id_write=0, bubble=1, flush=0 combinationally; stall counter loads LOAD_STALL_CYCLES-1; next state LOAD_STALL if that value >0, else RUN.
REQ-024 RUN, adv=1, hz=0, (i_branch_taken|i_jump)=1: pc_write=1, if_id_write=1, flush=1, bubble=0; state stays RUN.
REQ-025 Hazard SHALL take priority over branch/jump in same cycle (branch re-evaluated after stall).
REQ-026 RUN, adv=1, no hz, no transfer: pc_write=1, if_id_write=1, bubble=0, flush=0.
REQ-027 LOAD_STALL, adv=1: stall outputs as REQ-023, counter decrements; at counter==1 next state RUN; branch/jump ignored.
REQ-028 o_stall_count SHALL increment by 1 each adv=1 cycle with bubble=1, saturating at 0xFFFF.
REQ-029 i_halt=1 with adv=1 in any non-HALTED state: next state HALTED, o_halted=1 next edge; i_halt overrides hz and transfer for the state transition only (current-cycle outputs per REQ-023..027).
REQ-030 HALTED: pipe_en=0, pc_write=0, if_id_write=0, bubble=1, flush=0; exited only by reset; i_step_req ignored.
REQ-031 Latency: all enables combinational from state and inputs, zero-cycle; o_halted, o_state, o_stall_count registered.

Reset
REQ-032 i_rst_n=0 SHALL immediately force state=RUN, counter=0, o_halted=0, o_stall_count=0, regardless of clock.
REQ-033 Reset asserted mid-LOAD_STALL or in HALTED SHALL abandon the stall/halt; after deassertion first edge operates from RUN.
REQ-034 During reset combinational outputs follow RUN decode with state=RUN.

Verification
REQ-035 Load to $5 in ID/EX, IF/ID rs=$5 -> one cycle pc_write=0, if_id_write=0, bubble=1; o_stall_count 0->1; state stays RUN.
REQ-036 Same with i_rt_id_ex=0, or rt match with i_uses_rt_if_id=0 -> no stall, pc_write=1.
REQ-037 LOAD_STALL_CYCLES=3, hazard -> exactly 3 bubble cycles, o_state 00,01,01,00; branch_taken during cycles 2-3 gives flush=0.
REQ-038 hz=1 and i_branch_taken=1 same cycle -> bubble=1, flush=0; next cycle hz=0 branch=1 -> flush=1.
REQ-039 i_step_en=1, no step_req for 5 cycles with hz=1 -> all enables 0, o_stall_count unchanged; one step_req pulse -> one bubble, count +1.
REQ-040 i_halt pulse -> o_halted=1, o_state=10 next edge, pipe_en=0 forever; assert i_rst_n=0 mid-cycle -> o_halted=0, o_stall_count=0 immediately.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard controller bus bundle.
// Groups every pipeline-facing signal of hazard_controller. Clock and reset
// stay plain ports on the module.
//   master : pipeline side, drives hazard inputs and observes controls
//   slave  : hazard_controller side
// Handshake semantics: there is no valid/ready pair on this bus. Every input
// is a level sampled each cycle. Every enable output is a same-cycle
// combinational response to those levels and the current state.
interface hazard_controller_if #(
  parameter int TAM_DIREC_REG = 5
);
  logic [TAM_DIREC_REG-1:0] i_rs_if_id;
  logic [TAM_DIREC_REG-1:0] i_rt_if_id;
  logic                     i_uses_rt_if_id;
  logic [TAM_DIREC_REG-1:0] i_rt_id_ex;
  logic                     i_mem_read_id_ex;
  logic                     i_branch_taken;
  logic                     i_jump;
  logic                     i_halt;
  logic                     i_step_en;
  logic                     i_step_req;
  logic                     o_pipe_en;
  logic                     o_pc_write;
  logic                     o_if_id_write;
  logic                     o_id_ex_bubble;
  logic                     o_if_id_flush;
  logic                     o_halted;
  logic [1:0]               o_state;
  logic [15:0]              o_stall_count;

  modport master (
    output i_rs_if_id, i_rt_if_id, i_uses_rt_if_id, i_rt_id_ex,
           i_mem_read_id_ex, i_branch_taken, i_jump, i_halt,
           i_step_en, i_step_req,
    input  o_pipe_en, o_pc_write, o_if_id_write, o_id_ex_bubble,
           o_if_id_flush, o_halted, o_state, o_stall_count
  );

  modport slave (
    input  i_rs_if_id, i_rt_if_id, i_uses_rt_if_id, i_rt_id_ex,
           i_mem_read_id_ex, i_branch_taken, i_jump, i_halt,
           i_step_en, i_step_req,
    output o_pipe_en, o_pc_write, o_if_id_write, o_id_ex_bubble,
           o_if_id_flush, o_halted, o_state, o_stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller.
// Detects load-use hazards between ID/EX and IF/ID and inserts
// LOAD_STALL_CYCLES bubbles for each one. Flushes IF/ID on a taken branch
// or a jump. Freezes the pipeline on HALT, which only reset releases.
// Gates all progress with a debug single-step mode.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : hazard_controller_if.slave (hazard inputs, enables, debug state)
module hazard_controller #(
  parameter int TAM_DIREC_REG     = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hazard_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_HALTED     = 2'b10,
    ST_ILLEGAL    = 2'b11
  } state_t;

  // Bubbles still owed after the one issued on the detection cycle.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t      state;
  logic [2:0]  stall_left;
  logic        halted;
  logic [15:0] stall_count;

  logic [TAM_DIREC_REG-1:0] rs_if_id;
  logic [TAM_DIREC_REG-1:0] rt_if_id;
  logic [TAM_DIREC_REG-1:0] rt_id_ex;
  logic hz;
  logic adv;
  logic transfer;
  logic pipe_en;
  logic pc_write;
  logic if_id_write;
  logic id_ex_bubble;
  logic if_id_flush;
  logic count_bubble;

  assign rs_if_id = bus.i_rs_if_id;
  assign rt_if_id = bus.i_rt_if_id;
  assign rt_id_ex = bus.i_rt_id_ex;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign hz = bus.i_mem_read_id_ex && (rt_id_ex != '0) &&
              ((rt_id_ex == rs_if_id) ||
               (bus.i_uses_rt_if_id && (rt_id_ex == rt_if_id)));
  assign adv      = !bus.i_step_en || bus.i_step_req;
  assign transfer = bus.i_branch_taken || bus.i_jump;

  always_comb begin
    pipe_en      = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    case (state)
      ST_RUN: begin
        pipe_en = adv;
        if (adv) begin
          // A hazard wins over a transfer. The branch stays in IF/ID and is
          // re-evaluated once the stall clears.
          if (hz) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = transfer;
          end
        end
      end
      ST_LOAD_STALL: begin
        pipe_en      = adv;
        id_ex_bubble = adv;
      end
      ST_HALTED: begin
        id_ex_bubble = 1'b1;
      end
      default: begin
        // Unreachable encoding: every enable stays low for one cycle.
      end
    endcase
  end

  // HALTED drives a bubble too, but it is not a load-use bubble.
  assign count_bubble = adv && id_ex_bubble && (state != ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      stall_left  <= 3'd0;
      halted      <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (count_bubble && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      case (state)
        ST_RUN: begin
          if (adv) begin
            if (hz) begin
              stall_left <= STALL_RELOAD;
            end
            if (bus.i_halt) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else if (hz) begin
              state <= (STALL_RELOAD != 3'd0) ? ST_LOAD_STALL : ST_RUN;
            end
          end
        end
        ST_LOAD_STALL: begin
          if (adv) begin
            stall_left <= stall_left - 3'd1;
            if (bus.i_halt) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else if (stall_left == 3'd1) begin
              state <= ST_RUN;
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state      <= ST_RUN;
          stall_left <= 3'd0;
        end
      endcase
    end
  end

  assign bus.o_pipe_en      = pipe_en;
  assign bus.o_pc_write     = pc_write;
  assign bus.o_if_id_write  = if_id_write;
  assign bus.o_id_ex_bubble = id_ex_bubble;
  assign bus.o_if_id_flush  = if_id_flush;
  assign bus.o_halted       = halted;
  assign bus.o_state        = state;
  assign bus.o_stall_count  = stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic clk;
  logic rst1_n;
  logic rst3_n;

  hazard_controller_if #(.TAM_DIREC_REG(5)) if1 ();
  hazard_controller_if #(.TAM_DIREC_REG(5)) if3 ();

  hazard_controller #(.TAM_DIREC_REG(5), .LOAD_STALL_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .bus(if1.slave)
  );
  hazard_controller #(.TAM_DIREC_REG(5), .LOAD_STALL_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n), .bus(if3.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses;
    logic [4:0] rtex;
    logic       mem, br, jmp, halt, sen, sreq;
    logic [4:0] exp_en;   // {pipe_en, pc_write, if_id_write, bubble, flush}
    logic       exp_halted;
    logic [1:0] exp_state;
    logic       cnt_inc;
    logic       chk_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cnt1 = 0;
  int cnt3 = 0;
  logic [23:0] exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic uses,
                              logic [4:0] rtex, logic mem, logic br, logic jmp,
                              logic halt, logic sen, logic sreq, logic [4:0] en,
                              logic hl, logic [1:0] st, logic inc);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.uses = uses; v.rtex = rtex;
    v.mem = mem; v.br = br; v.jmp = jmp; v.halt = halt; v.sen = sen; v.sreq = sreq;
    v.exp_en = en; v.exp_halted = hl; v.exp_state = st; v.cnt_inc = inc;
    v.chk_cnt = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input bit which, input vec_t v);
    if (which) begin
      if3.i_rs_if_id = v.rs; if3.i_rt_if_id = v.rt; if3.i_uses_rt_if_id = v.uses;
      if3.i_rt_id_ex = v.rtex; if3.i_mem_read_id_ex = v.mem;
      if3.i_branch_taken = v.br; if3.i_jump = v.jmp; if3.i_halt = v.halt;
      if3.i_step_en = v.sen; if3.i_step_req = v.sreq;
    end else begin
      if1.i_rs_if_id = v.rs; if1.i_rt_if_id = v.rt; if1.i_uses_rt_if_id = v.uses;
      if1.i_rt_id_ex = v.rtex; if1.i_mem_read_id_ex = v.mem;
      if1.i_branch_taken = v.br; if1.i_jump = v.jmp; if1.i_halt = v.halt;
      if1.i_step_en = v.sen; if1.i_step_req = v.sreq;
    end
  endtask

  function automatic logic [4:0] sample_en(input bit which);
    if (which)
      return {if3.o_pipe_en, if3.o_pc_write, if3.o_if_id_write, if3.o_id_ex_bubble, if3.o_if_id_flush};
    return {if1.o_pipe_en, if1.o_pc_write, if1.o_if_id_write, if1.o_id_ex_bubble, if1.o_if_id_flush};
  endfunction

  function automatic logic [18:0] sample_reg(input bit which);
    if (which) return {if3.o_halted, if3.o_state, if3.o_stall_count};
    return {if1.o_halted, if1.o_state, if1.o_stall_count};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check enables mid-cycle and the
  // registered outputs just after the rising edge.
  task automatic cycle(input bit which, input vec_t v);
    int c;
    logic [4:0]  got_en;
    logic [18:0] got_reg;
    logic [23:0] e;
    c = which ? cnt3 : cnt1;
    if (v.cnt_inc) c++;
    @(negedge clk);
    drive(which, v);
    exp_q.push_back({v.exp_en, v.exp_halted, v.exp_state, 16'(c)});
    #1 got_en = sample_en(which);
    @(posedge clk);
    #1 got_reg = sample_reg(which);
    e = exp_q.pop_front();
    chk({v.name, " enables"}, 32'(got_en), 32'(e[23:19]));
    chk({v.name, " halted"}, 32'(got_reg[18]), 32'(e[18]));
    chk({v.name, " state"}, 32'(got_reg[17:16]), 32'(e[17:16]));
    if (v.chk_cnt) chk({v.name, " stall_count"}, 32'(got_reg[15:0]), 32'(e[15:0]));
    if (which) cnt3 = c; else cnt1 = c;
  endtask

  // Assert reset in the middle of a cycle and check it takes effect at once.
  task automatic reset_mid(input bit which, input string name);
    vec_t idle;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0);
    @(negedge clk);
    drive(which, idle);
    #2;
    if (which) rst3_n = 1'b0; else rst1_n = 1'b0;
    #1;
    chk({name, " regs"}, 32'(sample_reg(which)), 32'd0);
    chk({name, " enables"}, 32'(sample_en(which)), 32'b11100);
    @(negedge clk);
    if (which) begin rst3_n = 1'b1; cnt3 = 0; end
    else begin rst1_n = 1'b1; cnt1 = 0; end
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    logic hz;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0);

    rst1_n = 1'b0;
    rst3_n = 1'b0;
    drive(0, idle);
    drive(1, idle);
    #3;
    chk("reset1 regs", 32'(sample_reg(0)), 32'd0);
    chk("reset3 regs", 32'(sample_reg(1)), 32'd0);
    chk("reset1 enables", 32'(sample_en(0)), 32'b11100);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    // Table for the LOAD_STALL_CYCLES=1 instance; every row starts in RUN.
    tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    tbl.push_back(mk("hz_rs",      5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b10010, 0, 2'b00, 1));
    tbl.push_back(mk("rtex_zero",  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    tbl.push_back(mk("rt_unused",  1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    tbl.push_back(mk("hz_rt",      1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 5'b10010, 0, 2'b00, 1));
    tbl.push_back(mk("no_load",    5, 5, 1, 5, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    tbl.push_back(mk("branch",     2, 3, 1, 4, 1, 1, 0, 0, 0, 0, 5'b11101, 0, 2'b00, 0));
    tbl.push_back(mk("jump",       2, 3, 1, 4, 0, 0, 1, 0, 0, 0, 5'b11101, 0, 2'b00, 0));
    tbl.push_back(mk("hz_branch",  7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 5'b10010, 0, 2'b00, 1));
    tbl.push_back(mk("branch_aft", 7, 0, 0, 9, 1, 1, 0, 0, 0, 0, 5'b11101, 0, 2'b00, 0));
    tbl.push_back(mk("step_hold",  5, 0, 0, 5, 1, 0, 0, 0, 1, 0, 5'b00000, 0, 2'b00, 0));
    tbl.push_back(mk("step_go",    5, 0, 0, 5, 1, 0, 0, 0, 1, 1, 5'b10010, 0, 2'b00, 1));
    tbl.push_back(mk("step_brhold",0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5'b00000, 0, 2'b00, 0));
    foreach (tbl[i]) cycle(0, tbl[i]);

    // Single-step gating with a live hazard: five held cycles, then one step.
    for (int i = 0; i < 5; i++)
      cycle(0, mk("step_gate", 6, 0, 0, 6, 1, 0, 0, 0, 1, 0, 5'b00000, 0, 2'b00, 0));
    cycle(0, mk("step_pulse", 6, 0, 0, 6, 1, 0, 0, 0, 1, 1, 5'b10010, 0, 2'b00, 1));

    // Random operands in RUN against the hazard equation.
    for (int i = 0; i < 16; i++) begin
      v = mk("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0, 0, 0, 5'b0, 0, 2'b00, 0);
      hz = v.mem && (v.rtex != 0) && ((v.rtex == v.rs) || (v.uses && v.rtex == v.rt));
      v.exp_en = hz ? 5'b10010 : ((v.br || v.jmp) ? 5'b11101 : 5'b11100);
      v.cnt_inc = hz;
      cycle(0, v);
    end

    // Halt on the single-bubble instance, then reset releases it.
    cycle(0, mk("halt_pulse", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11100, 1, 2'b10, 0));
    for (int i = 0; i < 3; i++)
      cycle(0, mk("halted_hold", 5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 5'b00010, 1, 2'b10, 0));
    v = mk("halted_step", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 5'b00010, 1, 2'b10, 0);
    v.chk_cnt = 1'b0;
    cycle(0, v);
    reset_mid(0, "reset_halted");
    cycle(0, mk("after_reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));

    // Three-bubble instance: bubble train with branch ignored during the stall.
    cycle(1, mk("ls3_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    cycle(1, mk("ls3_hz",    5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b10010, 0, 2'b01, 1));
    cycle(1, mk("ls3_b2",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b10010, 0, 2'b01, 1));
    cycle(1, mk("ls3_b3",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b10010, 0, 2'b00, 1));
    cycle(1, mk("ls3_br",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11101, 0, 2'b00, 0));
    cycle(1, mk("ls3_hz2",   3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 5'b10010, 0, 2'b01, 1));
    cycle(1, mk("ls3_hold",  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5'b00000, 0, 2'b01, 0));
    cycle(1, mk("ls3_step",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b10010, 0, 2'b01, 1));
    reset_mid(1, "reset_stall");
    cycle(1, mk("after_reset3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 2'b00, 0));
    cycle(1, mk("halt_hz",   5, 0, 0, 5, 1, 1, 0, 1, 0, 0, 5'b10010, 1, 2'b10, 1));
    cycle(1, mk("halt3_hold",5, 0, 0, 5, 1, 0, 0, 0, 1, 0, 5'b00010, 1, 2'b10, 0));
    reset_mid(1, "reset_halted3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
